// File: rtl/alct_raw_pkg.sv
// Shared constants and FSM encoding for the raw-hit readout path.
package alct_raw_pkg;

  localparam int FRAME_W         = 384;
  localparam int WORD_W          = 16;
  localparam int WORDS_PER_FRAME = FRAME_W / WORD_W;
  localparam int MAX_NBX         = 31;
  localparam int BUF_DEPTH       = MAX_NBX + 1;
  localparam int BUF_AW          = $clog2(BUF_DEPTH);

  localparam logic [3:0] HDR0_CODE = 4'hD;
  localparam logic [3:0] HDR1_CODE = 4'hA;
  localparam logic [3:0] TRL_CODE  = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HEADER0,
    HEADER1,
    DATA,
    TRAILER
  } raw_state_t;

endpackage

// File: rtl/raw_window_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module raw_window_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int W     = 384
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/raw_readout.sv
// Captures a trigger-selected window of raw frames and serialises it as
// header, header, 16-bit data slices and trailer over a valid/ready link.
module raw_readout
  import alct_raw_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] din,
  input  logic               trig,
  input  logic [4:0]         nbx,
  input  logic [11:0]        bxn,
  output logic [WORD_W-1:0]  dout,
  output logic               dvalid,
  input  logic               dready,
  output logic               busy,
  output logic               trig_lost,
  output logic [7:0]         lost_cnt
);

  raw_state_t state, state_nxt;

  logic [4:0]         nbx_l;
  logic [11:0]        bxn_l;
  logic [BUF_AW-1:0]  fidx, fidx_nxt;
  logic [4:0]         widx, widx_nxt;
  logic               xfer, last_frame, last_word, wr_en;
  logic [FRAME_W-1:0] rd_frame;
  logic [WORD_W-1:0]  data_word;
  logic [11:0]        total;

  assign xfer       = dvalid & dready;
  assign last_frame = (fidx == nbx_l - 5'd1);
  assign last_word  = (widx == 5'(WORDS_PER_FRAME - 1));
  assign total      = 12'(3 + WORDS_PER_FRAME * int'(nbx_l));

  // Read address follows the next frame index, so the registered read data
  // always matches the frame being presented: the 1-cycle latency is hidden.
  raw_window_ram #(
    .DEPTH(BUF_DEPTH),
    .AW   (BUF_AW),
    .W    (FRAME_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(fidx),
    .wdata(din),
    .raddr(fidx_nxt),
    .rdata(rd_frame)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trig) state_nxt = (nbx == 5'd0) ? HEADER0 : CAPTURE;
      CAPTURE: if (last_frame) state_nxt = HEADER0;
      HEADER0: if (xfer) state_nxt = HEADER1;
      HEADER1: if (xfer) state_nxt = (nbx_l == 5'd0) ? TRAILER : DATA;
      DATA:    if (xfer && last_word && last_frame) state_nxt = TRAILER;
      TRAILER: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_word = '0;
    for (int unsigned i = 0; i < WORDS_PER_FRAME; i++) begin
      if (widx == 5'(i)) data_word = rd_frame[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    dvalid = 1'b0;
    dout   = '0;
    busy   = (state != IDLE);
    wr_en  = (state == CAPTURE);
    unique case (state)
      HEADER0: begin dvalid = 1'b1; dout = {HDR0_CODE, bxn_l}; end
      HEADER1: begin dvalid = 1'b1; dout = {HDR1_CODE, 7'b0, nbx_l}; end
      DATA:    begin dvalid = 1'b1; dout = data_word; end
      TRAILER: begin dvalid = 1'b1; dout = {TRL_CODE, total}; end
      default: ;
    endcase
  end

  always_comb begin
    fidx_nxt = '0;
    widx_nxt = '0;
    unique case (state)
      CAPTURE: fidx_nxt = last_frame ? '0 : fidx + 5'd1;
      DATA: begin
        fidx_nxt = fidx;
        widx_nxt = widx;
        if (xfer) begin
          if (last_word) begin
            widx_nxt = '0;
            fidx_nxt = last_frame ? '0 : fidx + 5'd1;
          end else begin
            widx_nxt = widx + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fidx  <= '0;
      widx  <= '0;
      nbx_l <= '0;
      bxn_l <= '0;
    end else begin
      fidx <= fidx_nxt;
      widx <= widx_nxt;
      if (state == IDLE && trig) begin
        nbx_l <= nbx;
        bxn_l <= bxn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_lost <= 1'b0;
      lost_cnt  <= '0;
    end else begin
      trig_lost <= trig && (state != IDLE);
      if (trig && (state != IDLE) && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_raw_readout.sv
// Directed bench for raw_readout: event formats, backpressure, lost triggers,
// mid-event reset and trigger timing at the event boundary.
module tb_raw_readout;

  logic         clk = 1'b0;
  logic         rst;
  logic [383:0] din;
  logic         trig;
  logic [4:0]   nbx;
  logic [11:0]  bxn;
  logic [15:0]  dout;
  logic         dvalid;
  logic         dready;
  logic         busy;
  logic         trig_lost;
  logic [7:0]   lost_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fid    = 0;
  int unsigned t0;

  raw_readout dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .trig     (trig),
    .nbx      (nbx),
    .bxn      (bxn),
    .dout     (dout),
    .dvalid   (dvalid),
    .dready   (dready),
    .busy     (busy),
    .trig_lost(trig_lost),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [383:0] frame_pat(input int unsigned id);
    logic [383:0] r;
    for (int w = 0; w < 24; w++) r[16*w +: 16] = {id[10:0], 5'(w)};
    return r;
  endfunction

  function automatic logic [15:0] exp_word(input int unsigned nb, input logic [11:0] bx,
                                           input int unsigned ts, input int unsigned k);
    int unsigned n, tot, id, w;
    n = 2 + 24 * nb;
    if (k == 0) return {4'hD, bx};
    if (k == 1) return {4'hA, 7'b0, nb[4:0]};
    if (k == n) begin
      tot = 3 + 24 * nb;
      return {4'hE, tot[11:0]};
    end
    id = ts + 1 + (k - 2) / 24;
    w  = (k - 2) % 24;
    return {id[10:0], w[4:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    fid++;
    din = frame_pat(fid);
  endtask

  task automatic fire(input logic [4:0] n, input logic [11:0] b, output int unsigned ts);
    nbx  = n;
    bxn  = b;
    trig = 1'b1;
    ts   = fid;
    step();
    trig = 1'b0;
    check("busy_after_trig", busy, 1);
  endtask

  task automatic drain(input int unsigned nb, input logic [11:0] bx, input int unsigned ts,
                       input bit bp, input bit lost, input int unsigned stop_after,
                       input bit trig_end);
    int unsigned nw, k, cyc, wait_first, pulses, sent;
    bit          first_seen, prev_stall, prev_trig, trig_now;
    logic [15:0] prev_dout;
    nw = 3 + 24 * nb;
    k = 0; cyc = 0; wait_first = 0; pulses = 0; sent = 0;
    first_seen = 0; prev_stall = 0; prev_trig = 0; prev_dout = '0;
    while (k < nw && cyc < 4000) begin
      dready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (lost) check("trig_lost_pulse", trig_lost, prev_trig);
      if (trig_lost) pulses++;
      if (prev_stall) begin
        check("stall_hold_valid", dvalid, 1);
        check("stall_hold_dout", dout, prev_dout);
      end
      if (!first_seen && dvalid) begin
        first_seen = 1;
        check("header_latency_ok", (wait_first <= nb + 1), 1);
      end
      if (!first_seen) wait_first++;
      else if (!bp) check("no_bubble", dvalid, 1);
      prev_stall = dvalid && !dready;
      prev_dout  = dout;
      trig_now   = 0;
      if (lost && sent < 300 && (cyc % 2) == 0) begin
        trig_now = 1;
        sent++;
      end
      if (dvalid && dready) begin
        check("word", dout, exp_word(nb, bx, ts, k));
        k++;
        if (trig_end && k == nw) trig_now = 1;
      end
      trig      = trig_now;
      prev_trig = trig_now;
      step();
      cyc++;
      if (stop_after != 0 && k == stop_after) break;
    end
    trig = 1'b0;
    if (stop_after == 0) check("word_count", k, nw);
    else check("partial_count", k, stop_after);
    if (lost) begin
      check("lost_pulse_total", pulses, 300);
      check("lost_cnt_saturated", lost_cnt, 255);
    end
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; nbx = '0; bxn = '0; dready = 1'b0;
    din = frame_pat(0);
    step();
    step();
    check("rst_dout", dout, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_trig_lost", trig_lost, 0);
    check("rst_lost_cnt", lost_cnt, 0);
    rst = 1'b0;
    step();

    // Basic event: 0xD123, 0xA002, 48 data words, 0xE033
    fire(5'd2, 12'h123, t0);
    drain(2, 12'h123, t0, 0, 0, 0, 0);
    check("basic_idle", busy, 0);
    step();

    // Zero window: 0xDFFF, 0xA000, 0xE003
    fire(5'd0, 12'hFFF, t0);
    drain(0, 12'hFFF, t0, 0, 0, 0, 0);
    step();

    // Full window under random backpressure, trailer 0xE2EB
    fire(5'd31, 12'h000, t0);
    drain(31, 12'h000, t0, 1, 0, 0, 0);
    step();

    // 300 triggers during one readout
    fire(5'd31, 12'h5A5, t0);
    drain(31, 12'h5A5, t0, 0, 1, 0, 0);
    check("lost_cnt_hold", lost_cnt, 255);
    step();

    // Reset in the middle of DATA
    fire(5'd5, 12'h0AB, t0);
    drain(5, 12'h0AB, t0, 0, 0, 10, 0);
    rst = 1'b1;
    step();
    check("midrst_dvalid", dvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_lost_cnt", lost_cnt, 0);
    rst = 1'b0;
    step();
    fire(5'd1, 12'h321, t0);
    drain(1, 12'h321, t0, 0, 0, 0, 0);
    step();

    // Trigger on the trailer-transfer edge is lost, the next one is accepted
    fire(5'd0, 12'h777, t0);
    drain(0, 12'h777, t0, 0, 0, 0, 1);
    check("edge_trig_lost", trig_lost, 1);
    check("edge_busy_low", busy, 0);
    check("edge_lost_cnt", lost_cnt, 1);
    fire(5'd1, 12'h778, t0);
    check("next_trig_not_lost", trig_lost, 0);
    drain(1, 12'h778, t0, 0, 0, 0, 0);
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/raw_readout.md
# raw_readout

Readout end of the raw-hit delay path. It captures a trigger-selected window of delayed 384-bit wire-group frames into a local buffer, then serialises them as 16-bit words with a header and a trailer over a valid/ready handshake toward the DAQ output mux. It sits between the raw delay line output and the DAQ word mux, and is the consumer of the delayed frame stream.

## Interface
- `FRAME_W`, 384: width of one raw frame.
- `WORD_W`, 16: output word width.
- `MAX_NBX`, 31: maximum window length, in frames. Sets the buffer depth to 32.

- `clk` in 1: system clock. Everything is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `din` in 384: delayed raw frame, new value every clock.
- `trig` in 1: readout request, sampled each clock.
- `nbx` in 5: window length in frames (0..31). Latched at trigger.
- `bxn` in 12: bunch-crossing number. Latched at trigger.
- `dout` out 16: output word.
- `dvalid` out 1: `dout` holds a valid word.
- `dready` in 1: downstream accepts the word.
- `busy` out 1: a capture or readout is in progress.
- `trig_lost` out 1: one-cycle pulse when a trigger arrives while busy.
- `lost_cnt` out 8: count of lost triggers. Saturates at 255.

## Operation
- FSM states: IDLE, CAPTURE, HEADER0, HEADER1, DATA, TRAILER.
- **IDLE**
  - `trig`=1 latches `nbx` and `bxn`, clears the frame index, and enters CAPTURE.
  - With latched `nbx`=0 it goes directly to HEADER0 instead.
- **CAPTURE**
  - Writes `din` to buffer[frame index] each cycle.
  - After `nbx` frames it moves to HEADER0.
- **Word formats**
  - HEADER0 word = {4'hD, bxn_l[11:0]}.
  - HEADER1 word = {4'hA, 7'b0, nbx_l[4:0]}.
  - DATA: for frame f = 0..nbx_l-1 and word w = 0..23, the word is frame_f[16w+15:16w]. Lowest slice goes first.
  - TRAILER word = {4'hE, total[11:0]}, where total = 3 + 24·nbx_l. Maximum is 747.
- **Transfer and state advance**
  - A word transfers on a cycle with `dvalid`&`dready`.
  - Each state advances only on a transfer.
  - A transfer in TRAILER returns the FSM to IDLE.
- **Handshake rules**
  - While `dvalid`=1 and `dready`=0, `dout` and `dvalid` hold stable.
  - `dvalid` never drops without a transfer.
- **Throughput**
  - With `dready` held high, `dvalid` stays high from HEADER0 through TRAILER, one word per clock, with no bubbles.
  - The buffer read latency is 1 cycle and must be hidden by prefetch.
- **Lost triggers**
  - A `trig` seen outside IDLE is ignored and pulses `trig_lost`.
  - `lost_cnt` then increments, saturating at 255.
- **`busy`**: high in every state except IDLE.

## Timing
- **Reset values**: `dout`=0, `dvalid`=0, `busy`=0, `trig_lost`=0, `lost_cnt`=0, FSM=IDLE.
- **Reset mid-operation**: the FSM returns to IDLE and `dvalid` is 0 on the next cycle. The partial event is discarded. No trailer is sent.
- **Capture window**: `trig` sampled at edge T → frames `din` at edges T+1 … T+nbx are captured. `busy`=1 from T+1.
- **First header**: HEADER0 `dvalid`=1 no later than edge T+nbx+2. For `nbx`=0, that is T+2.
- **Back-to-back triggers**: the trailer transfer at edge E → `busy`=0 after E. A `trig` at E+1 is accepted.
- **Trigger coincident with the trailer transfer**: a `trig` at E itself is lost.
- **`trig_lost` timing**: `trig_lost` is asserted on the cycle after the lost `trig`.
- **Index wrap**: the frame index and word index wrap to 0 at each frame or event start. They never exceed nbx_l-1 and 23 respectively.

## Structure
- **Shared package `alct_raw_pkg`** holds:
  - `FRAME_W`, `WORD_W`, `WORDS_PER_FRAME`=24.
  - Header/trailer codes 4'hD, 4'hA, 4'hE.
  - FSM state encodings.
- **Sub-module `raw_window_ram`**:
  - 32×384 buffer.
  - Simple dual port: one write port, one registered read port with 1-cycle latency.
  - Block-RAM style.
- **Top-level contents**: the FSM, counters, prefetch/output register, and lost-trigger logic.

## Test plan
- **Basic event**: `nbx`=2, `bxn`=0x123, din = frame counter pattern, `dready`=1.
  - Expect 0xD123, 0xA002, 48 data words matching the slices of frames T+1 and T+2, then 0xE033.
  - `dvalid` is continuous.
- **Zero window**: `nbx`=0, `bxn`=0xFFF → exactly 0xDFFF, 0xA000, 0xE003.
- **Backpressure**: `nbx`=31, `dready` toggled pseudo-randomly → 747 words, in order, none duplicated or dropped; `dout` stable while stalled; trailer 0xE2EB.
- **Lost triggers**: `trig` pulsed 300 times during one readout.
  - 300 `trig_lost` pulses; `lost_cnt` saturates at 255.
  - The event completes intact.
- **Reset mid-DATA**: assert `rst` after 10 transfers.
  - Next cycle: `dvalid`=0, `busy`=0.
  - A following `trig` with `nbx`=1 gives a clean 27-word event.
- **Trigger timing at the event boundary**:
  - `trig` at the trailer-transfer edge → lost.
  - `trig` one cycle later → accepted; the new event's header follows.
